// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: opcode constants used by the decoder too,
// FSM state encoding and the registered strobe bundle. Optional macro: SINGLE_STEP_EN.
package phase_sequencer_pkg;

   localparam logic [4:0] OP_STP  = 5'b00000;
   localparam logic [4:0] OP_LDR  = 5'b01110;
   localparam logic [2:0] OP3_LDA = 3'b110;

`ifdef SINGLE_STEP_EN
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FE    = 3'd1,
      ST_E1    = 3'd2,
      ST_E2    = 3'd3,
      ST_HALT  = 3'd4,
      ST_PAUSE = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FE    = 3'd1,
      ST_E1    = 3'd2,
      ST_E2    = 3'd3,
      ST_HALT  = 3'd4
   } state_t;
`endif

   typedef struct packed {
      logic fe;
      logic e1;
      logic e2;
      logic halted;
   } strobes_t;

endpackage

// File: rtl/phase_opclass.sv
// Combinational opcode classifier: flags STP and the opcodes that need a second execute phase.
module phase_opclass
   import phase_sequencer_pkg::*;
(
   input  logic [4:0] op,
   output logic       is_stp,
   output logic       needs_e2
);

   assign is_stp   = (op == OP_STP);
   assign needs_e2 = (op[4:2] == OP3_LDA) || (op == OP_LDR);

endmodule

// File: rtl/phase_sequencer.sv
// Control-phase generator: one-hot fe/e1/e2 strobes, fetch stall timeout, STP halt and
// retired-instruction counter. Optional macro: SINGLE_STEP_EN (step/step_mode ports, PAUSE state).
module phase_sequencer
   import phase_sequencer_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int FE_TMO = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      instr,
   input  logic             mem_ready,
   input  logic             run,
`ifdef SINGLE_STEP_EN
   input  logic             step,
   input  logic             step_mode,
`endif
   output logic             fe,
   output logic             e1,
   output logic             e2,
   output logic             halted,
   output logic             fetch_timeout,
   output logic [CNT_W-1:0] retired,
   output state_t           phase_state
);

   localparam int TMO_W = (FE_TMO < 2) ? 1 : $clog2(FE_TMO + 1);

   state_t           state, next_state, retire_dest;
   strobes_t         strb, strb_next;
   logic [TMO_W-1:0] stall_cnt;
   logic             is_stp, needs_e2;
   logic             retire, stall, resume;
   logic             unused_instr;

   phase_opclass u_opclass (
      .op       (instr[15:11]),
      .is_stp   (is_stp),
      .needs_e2 (needs_e2)
   );

   assign unused_instr = ^instr[10:0];

   assign retire = ((state == ST_E1) && !is_stp && !needs_e2) || (state == ST_E2);
   assign stall  = (state == ST_FE) && !mem_ready;
   assign resume = (state == ST_HALT) && run;

`ifdef SINGLE_STEP_EN
   assign retire_dest = step_mode ? ST_PAUSE : ST_FE;
`else
   assign retire_dest = ST_FE;
`endif

   // State register; strobes are registered from the next-state decode so they leave flops directly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         strb  <= '0;
      end else begin
         state <= next_state;
         strb  <= strb_next;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (run) next_state = ST_FE;
         ST_FE:   if (mem_ready) next_state = ST_E1;
         ST_E1: begin
            if (is_stp)        next_state = ST_HALT;
            else if (needs_e2) next_state = ST_E2;
            else               next_state = retire_dest;
         end
         ST_E2:   next_state = retire_dest;
         ST_HALT: if (run) next_state = ST_FE;
`ifdef SINGLE_STEP_EN
         ST_PAUSE: if (step || !step_mode) next_state = ST_FE;
`endif
         default: next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      strb_next = '0;
      case (next_state)
         ST_FE:   strb_next.fe     = 1'b1;
         ST_E1:   strb_next.e1     = 1'b1;
         ST_E2:   strb_next.e2     = 1'b1;
         ST_HALT: strb_next.halted = 1'b1;
         default: strb_next = '0;
      endcase
   end

   // Stall counter saturates at FE_TMO; the timeout flag sets on the edge the count reaches it.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt     <= '0;
         fetch_timeout <= 1'b0;
         retired       <= '0;
      end else begin
         if (retire) retired <= retired + CNT_W'(1);
         if (stall) begin
            if (stall_cnt != TMO_W'(FE_TMO)) stall_cnt <= stall_cnt + TMO_W'(1);
         end else begin
            stall_cnt <= '0;
         end
         if (resume)
            fetch_timeout <= 1'b0;
         else if ((FE_TMO != 0) && stall && (stall_cnt == TMO_W'(FE_TMO - 1)))
            fetch_timeout <= 1'b1;
      end
   end

   assign fe          = strb.fe;
   assign e1          = strb.e1;
   assign e2          = strb.e2;
   assign halted      = strb.halted;
   assign phase_state = state;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed per-cycle vectors push expected outputs tagged with the
// cycle they belong to; a negedge monitor pops and compares. Build with SINGLE_STEP_EN for step tests.
module tb_phase_sequencer;
   import phase_sequencer_pkg::*;

   localparam logic [4:0] F_0  = 5'b00000;
   localparam logic [4:0] F_FE = 5'b10000;
   localparam logic [4:0] F_E1 = 5'b01000;
   localparam logic [4:0] F_E2 = 5'b00100;
   localparam logic [4:0] F_H  = 5'b00010;
   localparam logic [4:0] F_T  = 5'b00001;

   logic        clk;
   logic        reset, run, mem_ready;
   logic [15:0] instr;
`ifdef SINGLE_STEP_EN
   logic        step, step_mode;
`endif
   logic        fe, e1, e2, halted, fetch_timeout;
   logic [15:0] retired;
   state_t      phase_state;

   logic [15:0] cyc_cnt;
   logic [36:0] exp_q[$];
   int          checks;
   int          errors;

   phase_sequencer #(.CNT_W(16), .FE_TMO(15)) dut (
      .clk           (clk),
      .reset         (reset),
      .instr         (instr),
      .mem_ready     (mem_ready),
      .run           (run),
`ifdef SINGLE_STEP_EN
      .step          (step),
      .step_mode     (step_mode),
`endif
      .fe            (fe),
      .e1            (e1),
      .e2            (e2),
      .halted        (halted),
      .fetch_timeout (fetch_timeout),
      .retired       (retired),
      .phase_state   (phase_state)
   );

   // clock and cycle tag
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc_cnt = '0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 16'd1;

   // driver: inputs applied now are sampled at the next edge; the expectation is for the cycle after it
   task automatic tick(input logic r, input logic rn, input logic mr, input logic [15:0] ins,
                       input logic [4:0] fl, input logic [15:0] ret);
      reset     = r;
      run       = rn;
      mem_ready = mr;
      instr     = ins;
      exp_q.push_back({cyc_cnt + 16'd1, fl, ret});
      @(posedge clk);
      #1;
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [36:0] e;
      logic [20:0] act;
      while (exp_q.size() > 0 && exp_q[0][36:21] <= cyc_cnt) begin
         e   = exp_q.pop_front();
         act = {fe, e1, e2, halted, fetch_timeout, retired};
         checks++;
         if (e[36:21] != cyc_cnt) begin
            errors++;
            $display("FAIL stale_expect cycle %0d expected for cycle %0d", cyc_cnt, e[36:21]);
         end else if (act != e[20:0]) begin
            errors++;
            $display("FAIL cycle %0d fe/e1/e2/halt/tmo got %b required %b retired got %0d required %0d",
                     cyc_cnt, act[20:16], e[20:16], act[15:0], e[15:0]);
         end
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      run       = 1'b0;
      mem_ready = 1'b1;
      instr     = 16'h0800;
`ifdef SINGLE_STEP_EN
      step      = 1'b0;
      step_mode = 1'b0;
`endif
      @(posedge clk);
      #1;

      // 1: reset then ADR stream, fe/e1 alternate
      tick(1, 0, 1, 16'h0800, F_0, 0);
      tick(0, 1, 1, 16'h0800, F_FE, 0);
      tick(0, 1, 1, 16'h0800, F_E1, 0);
      for (int k = 1; k <= 3; k++) begin
         tick(0, 1, 1, 16'h0800, F_FE, 16'(k));
         tick(0, 1, 1, 16'h0800, F_E1, 16'(k));
      end

      // 2: LDA takes fe,e1,e2 and retires only after e2
      tick(0, 1, 1, 16'hC000, F_E2, 3);
      tick(0, 1, 1, 16'hC000, F_FE, 4);
      tick(0, 1, 1, 16'hC000, F_E1, 4);
      tick(0, 1, 1, 16'hC000, F_E2, 4);
      tick(0, 1, 1, 16'hC000, F_FE, 5);

      // 3: STP halts without retiring; run resumes with fe
      tick(0, 0, 1, 16'h0000, F_E1, 5);
      tick(0, 0, 1, 16'h0000, F_H, 5);
      tick(0, 0, 1, 16'h0000, F_H, 5);
      tick(0, 1, 1, 16'h0800, F_FE, 5);
      tick(0, 1, 1, 16'h0800, F_E1, 5);
      tick(0, 1, 1, 16'h0800, F_FE, 6);

      // 4: 15 stall cycles raise the sticky timeout; run in HALT clears it
      for (int k = 0; k < 14; k++) tick(0, 1, 0, 16'h0800, F_FE, 6);
      tick(0, 1, 0, 16'h0800, F_FE | F_T, 6);
      tick(0, 1, 1, 16'h0800, F_E1 | F_T, 6);
      tick(0, 1, 1, 16'h0800, F_FE | F_T, 7);
      tick(0, 0, 1, 16'h0000, F_E1 | F_T, 7);
      tick(0, 0, 1, 16'h0000, F_H | F_T, 7);
      tick(0, 1, 1, 16'h0800, F_FE, 7);

      // stall counter restarts on every fetch: two 10-cycle stalls never time out
      for (int k = 0; k < 10; k++) tick(0, 1, 0, 16'h0800, F_FE, 7);
      tick(0, 1, 1, 16'h0800, F_E1, 7);
      tick(0, 1, 1, 16'h0800, F_FE, 8);
      for (int k = 0; k < 10; k++) tick(0, 1, 0, 16'h0800, F_FE, 8);
      tick(0, 1, 1, 16'h0800, F_E1, 8);
      tick(0, 1, 1, 16'h0800, F_FE, 9);

      // 5: reset during E2 clears everything and returns to IDLE
      tick(0, 1, 1, 16'hC000, F_E1, 9);
      tick(0, 1, 1, 16'hC000, F_E2, 9);
      tick(1, 1, 1, 16'hC000, F_0, 0);
      tick(0, 0, 1, 16'h0800, F_0, 0);
      tick(0, 0, 1, 16'h0800, F_0, 0);
      tick(0, 1, 1, 16'h0800, F_FE, 0);
      tick(0, 1, 1, 16'h0800, F_E1, 0);

`ifdef SINGLE_STEP_EN
      // 6: step mode pauses after each retirement until step
      step_mode = 1'b1;
      tick(0, 1, 1, 16'h0800, F_0, 1);
      tick(0, 1, 1, 16'h0800, F_0, 1);
      tick(0, 1, 1, 16'h0800, F_0, 1);
      step = 1'b1;
      tick(0, 1, 1, 16'h0800, F_FE, 1);
      step = 1'b0;
      tick(0, 1, 1, 16'h0800, F_E1, 1);
      tick(0, 1, 1, 16'h0800, F_0, 2);
      tick(0, 1, 1, 16'h0800, F_0, 2);
      step_mode = 1'b0;
      tick(0, 1, 1, 16'h0800, F_FE, 2);
      tick(0, 1, 1, 16'h0800, F_E1, 2);
      tick(0, 1, 1, 16'h0800, F_FE, 3);
`else
      tick(0, 1, 1, 16'h0800, F_FE, 1);
      tick(0, 1, 1, 16'h0800, F_E1, 1);
      tick(0, 1, 1, 16'h0800, F_FE, 2);
`endif

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending expectations got %0d required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
